// File: rtl/sead_encoder_pipe.sv
// sead_encoder_pipe
//   Two-stage valid/ready pipeline that computes per-chunk SEC-DED parity for
//   the protected datapath (register file / data-memory write ports).
//   S1 captures the word together with its chunked (optionally interleaved) bit
//   layout. S2 captures the unmodified word plus one encoder_comb result per
//   chunk. The word and its parity leave together on out_*.
//   A saturating counter of output handshakes supports fault-campaign accounting.
//
//   Parity code (encoder_comb):
//     Data bits fill the non-power-of-two Hamming positions 3,5,6,7,9,...
//     Parity bit k (k < PAR_W-1) is the XOR of the data bits whose position has
//     bit k set. The top parity bit is the overall parity of the data bits and
//     the Hamming bits.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    upstream word valid
//   in_ready    block accepts a word this cycle
//   in_data     word to protect               [DATA_W]
//   out_valid   encoded word valid
//   out_ready   downstream accepts this cycle
//   out_data    original (non-interleaved) word [DATA_W]
//   out_parity  chunk c parity on [c*PAR_W +: PAR_W]
//   clr_count   synchronous clear of enc_count (wins over an increment)
//   enc_count   saturating count of output handshakes [CNT_W]
module sead_encoder_pipe #(
  parameter int DATA_W     = 32,
  parameter int CHUNK_W    = 11,
  parameter int PAR_W      = 5,
  parameter int INTERLEAVE = 1,
  parameter int CNT_W      = 16,
  localparam int NUM_CHUNKS = (DATA_W + CHUNK_W - 1) / CHUNK_W,
  localparam int PARITY_W   = NUM_CHUNKS * PAR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [PARITY_W-1:0] out_parity,
  input  logic                clr_count,
  output logic [CNT_W-1:0]    enc_count
);

  localparam int FLAT_W = NUM_CHUNKS * CHUNK_W;

  // SEC-DED parity of one chunk.
  function automatic logic [PAR_W-1:0] encoder_comb(input logic [CHUNK_W-1:0] d);
    logic [PAR_W-1:0] p;
    int j;
    p = '0;
    j = 0;
    for (int pos = 3; pos < (1 << (PAR_W - 1)); pos++) begin
      if (((pos & (pos - 1)) != 0) && (j < CHUNK_W)) begin
        for (int k = 0; k < PAR_W - 1; k++) begin
          if (pos[k]) p[k] ^= d[j];
        end
        j++;
      end
    end
    p[PAR_W-1] = (^d) ^ (^p);
    return p;
  endfunction

  // Chunk layout of the incoming word. Bits above a chunk's populated width
  // stay zero, so short chunks are zero-padded in their MSBs.
  logic [FLAT_W-1:0] chunks_comb;

  if (INTERLEAVE != 0) begin : g_sead
    // Bit i lands in chunk (i % NUM_CHUNKS) at position (i / NUM_CHUNKS), so
    // adjacent bits (a multi-bit upset) fall into different chunks.
    always_comb begin
      // NOTE: default first so every path assigns every bit; no latch is inferred.
      chunks_comb = '0;
      for (int i = 0; i < DATA_W; i++) begin
        chunks_comb[(i % NUM_CHUNKS) * CHUNK_W + i / NUM_CHUNKS] = in_data[i];
      end
    end
  end else begin : g_contig
    always_comb begin
      chunks_comb = '0;
      chunks_comb[DATA_W-1:0] = in_data;
    end
  end

  // Elastic control: a stage advances when it is empty or its consumer takes
  // its word this cycle. in_ready is combinational from out_ready.
  logic s1_v;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_v || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: word and chunk layout.
  logic [DATA_W-1:0] s1_data;
  logic [FLAT_W-1:0] s1_chunks;

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, because out_data/out_parity must read 0 after reset.
    if (rst) begin
      s1_v      <= 1'b0;
      s1_data   <= '0;
      s1_chunks <= '0;
    end else if (s1_adv) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      s1_v <= in_valid;
      if (in_valid) begin
        s1_data   <= in_data;
        s1_chunks <= chunks_comb;
      end
    end
  end

  // One encoder per chunk, fed from S1.
  logic [PARITY_W-1:0] s1_par;

  always_comb begin
    s1_par = '0;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      s1_par[c*PAR_W +: PAR_W] = encoder_comb(s1_chunks[c*CHUNK_W +: CHUNK_W]);
    end
  end

  // Stage 2: drives the outputs. Holding while stalled keeps out_* stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_parity <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_v;
      if (s1_v) begin
        out_data   <= s1_data;
        out_parity <= s1_par;
      end
    end
  end

  // Saturating handshake counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      enc_count <= '0;
    end else if (out_valid && out_ready && (enc_count != {CNT_W{1'b1}})) begin
      enc_count <= enc_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sead_encoder_pipe.sv
// tb_sead_encoder_pipe
//   Directed bench for sead_encoder_pipe. Two instances share clk/rst:
//     u_main : defaults (DATA_W=32, SEAD interleave, CNT_W=16)
//     u_nar  : DATA_W=16, contiguous chunks, CNT_W=4
//   Expected parities are hand-derived constants; the random stream uses an
//   independent mask-based model of the 11-bit SEC-DED code.
module tb_sead_encoder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_clr;
  logic [31:0] m_in_data, m_out_data;
  logic [14:0] m_out_parity;
  logic [15:0] m_count;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_clr;
  logic [15:0] n_in_data, n_out_data;
  logic [9:0]  n_out_parity;
  logic [3:0]  n_count;

  sead_encoder_pipe u_main (
    .clk(clk), .rst(rst),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
    .out_parity(m_out_parity), .clr_count(m_clr), .enc_count(m_count)
  );

  sead_encoder_pipe #(.DATA_W(16), .INTERLEAVE(0), .CNT_W(4)) u_nar (
    .clk(clk), .rst(rst),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .out_parity(n_out_parity), .clr_count(n_clr), .enc_count(n_count)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 11-bit SEC-DED: Hamming positions 3,5,6,7,9..15 for d0..d10.
  function automatic logic [4:0] enc11(input logic [10:0] d);
    logic [4:0] p;
    p[0] = ^(d & 11'h55B);
    p[1] = ^(d & 11'h66D);
    p[2] = ^(d & 11'h78E);
    p[3] = ^(d & 11'h7F0);
    p[4] = (^d) ^ (^p[3:0]);
    return p;
  endfunction

  // DATA_W=32 interleave: chunk c bit k = w[3k+c]; chunk 2 has 10 bits.
  function automatic logic [14:0] sead32(input logic [31:0] w);
    logic [10:0] ch [3];
    for (int c = 0; c < 3; c++) begin
      ch[c] = '0;
      for (int k = 0; k < 11; k++) begin
        if (k * 3 + c < 32) ch[c][k] = w[k*3+c];
      end
    end
    return {enc11(ch[2]), enc11(ch[1]), enc11(ch[0])};
  endfunction

  function automatic logic [9:0] par16(input logic [15:0] w);
    return {enc11({6'b0, w[15:11]}), enc11(w[10:0])};
  endfunction

  function automatic logic [15:0] word_n(input int i);
    logic [15:0] w;
    if (i == 0)      w = 16'h0801;
    else if (i == 1) w = 16'hFFFF;
    else             w = 16'(i * 16'h1357);
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    m_in_valid = 1'b0; m_out_ready = 1'b0; m_clr = 1'b0; m_in_data = '0;
    n_in_valid = 1'b0; n_out_ready = 1'b0; n_clr = 1'b0; n_in_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Push one word into an empty u_main and capture what comes out.
  task automatic m_send_one(input logic [31:0] d, output logic [31:0] od,
                            output logic [14:0] op);
    bit got;
    got = 1'b0;
    od  = '0;
    op  = '0;
    m_out_ready = 1'b1;
    m_in_valid  = 1'b1;
    m_in_data   = d;
    tick();
    m_in_valid = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (m_out_valid) begin
        od  = m_out_data;
        op  = m_out_parity;
        got = 1'b1;
      end
      tick();
    end
    check("send_one_timeout", got, 1);
  endtask

  logic [31:0] exp_q[$];
  int          sent, popped, first_ov;
  bit          got, stale, prev_stall;
  logic [31:0] prev_d, w, od;
  logic [14:0] prev_p, op;

  typedef struct {
    logic [31:0] data;
    logic [14:0] par;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{32'h0000_0001, 15'h0013};
    vecs[1] = '{32'h0000_0004, 15'h4C00};
    vecs[2] = '{32'h8000_0000, 15'h03E0};
    vecs[3] = '{32'hFFFF_FFFF, 15'h03FF};

    // Reset state and zero stream with latency.
    do_reset();
    check("rst_in_ready", m_in_ready, 1);
    check("rst_outputs", {m_out_valid, m_out_data, m_out_parity, m_count}, 0);
    m_out_ready = 1'b1; m_in_data = '0; m_in_valid = 1'b1;
    sent = 0; popped = 0; first_ov = -1;
    for (int c = 0; c < 12; c++) begin
      if (m_out_valid) begin
        if (first_ov < 0) first_ov = c;
        check("t1_zero_par", m_out_parity, 0);
        popped++;
      end
      if (m_in_valid && m_in_ready) sent++;
      tick();
      if (sent == 4) m_in_valid = 1'b0;
    end
    check("t1_latency", first_ov, 2);
    check("t1_words", popped, 4);
    check("t1_count", m_count, 4);

    // Directed single words through the SEAD interleave.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m_send_one(vecs[i].data, od, op);
      check("t2_data", od, vecs[i].data);
      check("t2_parity", op, vecs[i].par);
    end

    // Random stream against the model, with stall stability.
    do_reset();
    sent = 0; popped = 0; prev_stall = 1'b0;
    for (int c = 0; c < 20000 && (sent < 1000 || exp_q.size() > 0); c++) begin
      if (prev_stall)
        check("t3_hold", {m_out_valid, m_out_data, m_out_parity}, {1'b1, prev_d, prev_p});
      m_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      m_in_data   = $urandom;
      m_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (m_out_valid && m_out_ready) begin
        check("t3_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("t3_word", {m_out_data, m_out_parity}, {w, sead32(w)});
          popped++;
        end
      end
      if (m_in_valid && m_in_ready) begin
        exp_q.push_back(m_in_data);
        sent++;
      end
      prev_stall = m_out_valid && !m_out_ready;
      prev_d = m_out_data;
      prev_p = m_out_parity;
      tick();
    end
    m_in_valid = 1'b0;
    check("t3_sent", sent, 1000);
    check("t3_popped", popped, 1000);
    check("t3_count", m_count, 1000);

    // Fill, stall, drain.
    do_reset();
    m_out_ready = 1'b0; m_in_valid = 1'b1; m_in_data = 32'h1234_5678;
    #1;
    check("t4_rdy0", m_in_ready, 1);
    tick();
    m_in_data = 32'hCAFE_0001;
    check("t4_rdy1", m_in_ready, 1);
    tick();
    m_in_data = 32'h0BAD_F00D;
    for (int c = 0; c < 5; c++) begin
      check("t4_stall", {m_in_ready, m_out_valid, m_out_data}, {1'b0, 1'b1, 32'h1234_5678});
      tick();
    end
    m_in_valid = 1'b0; m_out_ready = 1'b1;
    #1;
    check("t4_drain_a", {m_out_valid, m_out_data, m_out_parity},
          {1'b1, 32'h1234_5678, sead32(32'h1234_5678)});
    tick();
    check("t4_drain_b", {m_out_valid, m_out_data, m_out_parity},
          {1'b1, 32'hCAFE_0001, sead32(32'hCAFE_0001)});
    tick();
    check("t4_empty", {m_out_valid, m_in_ready}, 2'b01);
    check("t4_count", m_count, 2);

    // Narrow instance: contiguous chunks, counter saturation, clear priority.
    do_reset();
    n_out_ready = 1'b1; sent = 0; popped = 0;
    for (int c = 0; c < 60 && popped < 17; c++) begin
      n_in_data  = word_n(sent);
      n_in_valid = (sent < 17);
      #1;
      if (n_out_valid && n_out_ready) begin
        if (popped == 0)      check("t5_par_0801", n_out_parity, 10'h273);
        else if (popped == 1) check("t5_par_ffff", n_out_parity, 10'h1DF);
        else                  check("t5_par", {n_out_data, n_out_parity},
                                    {word_n(popped), par16(word_n(popped))});
        popped++;
      end
      if (n_in_valid && n_in_ready) sent++;
      tick();
    end
    n_in_valid = 1'b0;
    check("t5_popped", popped, 17);
    check("t5_saturate", n_count, 15);
    n_in_valid = 1'b1; n_in_data = 16'h00AA;
    tick();
    n_in_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (n_out_valid) begin
        n_clr = 1'b1;
        got   = 1'b1;
      end
      tick();
    end
    n_clr = 1'b0;
    check("t5_clr_seen", got, 1);
    check("t5_clr_wins", n_count, 0);

    // Reset with two words in flight, on both instances.
    do_reset();
    m_in_valid = 1'b1; m_out_ready = 1'b1; m_in_data = 32'h5555_AAAA;
    n_in_valid = 1'b1; n_out_ready = 1'b1; n_in_data = 16'h3C3C;
    for (int c = 0; c < 4; c++) tick();
    m_in_valid = 1'b0; m_out_ready = 1'b0;
    n_in_valid = 1'b0; n_out_ready = 1'b0;
    #1;
    check("t6_pre_main", {m_out_valid, m_in_ready, m_count}, {1'b1, 1'b0, 16'd2});
    check("t6_pre_nar", {n_out_valid, n_in_ready, n_count}, {1'b1, 1'b0, 4'd2});
    rst = 1'b1;
    tick();
    check("t6_rst_main", {m_out_valid, m_count}, 0);
    check("t6_rst_nar", {n_out_valid, n_count}, 0);
    rst = 1'b0;
    m_out_ready = 1'b1; n_out_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 5; c++) begin
      stale |= m_out_valid | n_out_valid;
      tick();
    end
    check("t6_no_stale", stale, 0);
    check("t6_ready", {m_in_ready, n_in_ready}, 2'b11);
    check("t6_count_after", {m_count, n_count}, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
